// File: rtl/tx_packet_scheduler_if.sv
// tx_packet_scheduler_if: requester queues, transmitter command and monitored MAC TX write side.
interface tx_packet_scheduler_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 25
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      cmd_send;
   logic [ADDR_W-1:0]         start_ram_addr;
   logic                      ff_tx_wren;
   logic                      ff_tx_eop;
   logic                      ff_tx_rdy;
   logic                      busy;
   logic                      done;
   logic [1:0]                done_id;
   logic                      timeout_err;
   logic                      addr_err;
   modport master (
      output req_valid, req_addr, ff_tx_wren, ff_tx_eop, ff_tx_rdy,
      input  req_ready, cmd_send, start_ram_addr, busy, done, done_id, timeout_err, addr_err
   );
   modport slave (
      input  req_valid, req_addr, ff_tx_wren, ff_tx_eop, ff_tx_rdy,
      output req_ready, cmd_send, start_ram_addr, busy, done, done_id, timeout_err, addr_err
   );
endinterface

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: per-requester address FIFOs, round-robin pick, one packet at a time
// into the transmitter with completion timeout and inter-packet gap.
module tx_packet_scheduler #(
   parameter int NUM_REQ    = 2,
   parameter int QDEPTH     = 4,
   parameter int ADDR_W     = 25,
   parameter int CMD_CYCLES = 2,
   parameter int GAP_CYCLES = 12,
   parameter int TIMEOUT    = 4096
) (
   input logic clk_original,
   input logic rst,
   tx_packet_scheduler_if.slave io_bus
);
   localparam int PW = $clog2(QDEPTH);
   typedef enum logic [1:0] {IDLE, CMD, WAIT_DONE, GAP} state_t;
   state_t            r_state, w_next;
   logic [15:0]       r_cnt;
   logic [1:0]        r_last, r_id, w_win, w_idx;
   logic              w_found, w_pop, w_cmpl, w_tmo;
   logic              r_cmd, r_busy, r_done, r_tmo, r_aerr;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        w_ne, w_zerr;
   logic [ADDR_W-1:0] w_head [4];
   for (genvar g = 0; g < 4; g++) begin : g_q
      if (g < NUM_REQ) begin : g_on
         logic [ADDR_W-1:0] r_mem [QDEPTH];
         logic [PW-1:0]     r_wr, r_rd;
         logic [PW:0]       r_lvl;
         logic [ADDR_W-1:0] w_addr;
         logic              w_push, w_popq, w_rdy;
         assign w_addr = io_bus.req_addr[g*ADDR_W +: ADDR_W];
         assign w_popq = w_pop && w_win == 2'(g);
         // a full queue still accepts when it is being popped in the same cycle
         assign w_rdy = r_lvl != (PW+1)'(QDEPTH) || w_popq;
         assign w_push = io_bus.req_valid[g] && w_rdy && w_addr != '0;
         assign w_zerr[g] = io_bus.req_valid[g] && w_rdy && w_addr == '0;
         assign w_ne[g] = r_lvl != '0;
         assign w_head[g] = r_mem[r_rd];
         assign io_bus.req_ready[g] = w_rdy;
         always_ff @(posedge clk_original or posedge rst) begin
            if (rst) begin
               r_wr  <= '0;
               r_rd  <= '0;
               r_lvl <= '0;
            end else begin
               r_wr  <= r_wr + PW'(w_push);
               r_rd  <= r_rd + PW'(w_popq);
               r_lvl <= r_lvl + (PW+1)'(w_push) - (PW+1)'(w_popq);
            end
         end
         always_ff @(posedge clk_original)
            if (w_push) r_mem[r_wr] <= w_addr;
      end else begin : g_off
         assign w_zerr[g] = 1'b0;
         assign w_ne[g]   = 1'b0;
         assign w_head[g] = '0;
      end
   end
   // descending scan so the nearest requester after last_grant is the final writer
   always_comb begin
      w_found = 1'b0;
      w_win   = r_last;
      w_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = 2'((int'(r_last) + k) % NUM_REQ);
         if (w_ne[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_cmpl = 1'b0;
      w_tmo  = 1'b0;
      case (r_state)
         IDLE: begin
            w_pop  = w_found;
            w_next = w_found ? CMD : IDLE;
         end
         CMD: w_next = r_cnt == 16'(CMD_CYCLES-1) ? WAIT_DONE : CMD;
         WAIT_DONE: begin
            w_cmpl = io_bus.ff_tx_wren && io_bus.ff_tx_eop && io_bus.ff_tx_rdy;
            w_tmo  = !w_cmpl && r_cnt == 16'(TIMEOUT-1);
            w_next = (w_cmpl || w_tmo) ? GAP : WAIT_DONE;
         end
         GAP: w_next = r_cnt == 16'(GAP_CYCLES-1) ? IDLE : GAP;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_original or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk_original or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_last <= 2'(NUM_REQ-1);
         r_id   <= '0;
         r_addr <= '0;
         r_cmd  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_tmo  <= 1'b0;
         r_aerr <= 1'b0;
      end else begin
         r_cnt  <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
         r_cmd  <= w_next == CMD;
         r_busy <= r_state != IDLE;
         r_done <= w_cmpl;
         r_tmo  <= w_tmo;
         r_aerr <= |w_zerr;
         if (w_pop) begin
            r_addr <= w_head[w_win];
            r_id   <= w_win;
            r_last <= w_win;
         end else if (r_state == GAP && w_next == IDLE) begin
            r_addr <= '0;
         end
      end
   end
   assign io_bus.cmd_send       = r_cmd;
   assign io_bus.start_ram_addr = r_addr;
   assign io_bus.busy           = r_busy;
   assign io_bus.done           = r_done;
   assign io_bus.done_id        = r_id;
   assign io_bus.timeout_err    = r_tmo;
   assign io_bus.addr_err       = r_aerr;
endmodule
